// File: rtl/lsu.sv
// Load/store unit: accepts core requests over valid/ready, drives a
// request/grant/rvalid memory port, and returns a one-cycle response with
// sign/zero-extended load data.
// Optional feature macro: LSU_MISALIGN_EN -- when defined, misaligned
// accesses execute (split into two beats when they cross a bus word);
// when undefined, every misaligned access faults.
module lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_store,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_fault,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN/8-1:0] o_mem_we,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned SW = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {
    StIdle, StReq0, StWait0, StReq1, StWait1, StResp
  } state_e;

  state_e            r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_fault;
  logic [XLEN-1:0]   r_rsp_rdata;
  logic              r_mem_req;
  logic [XLEN-1:0]   r_mem_addr;
  logic [NB-1:0]     r_mem_we;
  logic [XLEN-1:0]   r_mem_wdata;
  logic              r_store;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [OW-1:0]     r_off;
  logic              r_split;
  logic [XLEN-1:0]   r_b1_addr;
  logic [NB-1:0]     r_b1_we;
  logic [XLEN-1:0]   r_b1_wdata;
  logic [XLEN-1:0]   r_d0;

  // Request-side decode (valid only while idle).
  logic [OW-1:0]     w_off;
  logic [3:0]        w_bytes;
  logic [2*NB-1:0]   w_bmask;
  logic [2*NB-1:0]   w_mask;
  logic [SW-1:0]     w_sh0_in;
  logic [SW-1:0]     w_sh1_in;
  logic [XLEN-1:0]   w_addr0;
  logic [XLEN-1:0]   w_addr1;
  logic [XLEN-1:0]   w_wdata0;
  logic [XLEN-1:0]   w_wdata1;
  logic              w_split;
  logic              w_fault;

  // Load-side assembly and extension.
  logic [SW-1:0]     w_ld_sh0;
  logic [SW-1:0]     w_ld_sh1;
  logic [XLEN-1:0]   w_d0;
  logic [XLEN-1:0]   w_d1;
  logic [XLEN-1:0]   w_raw;
  logic [XLEN-1:0]   w_lowmask;
  logic              w_sign;
  logic [XLEN-1:0]   w_ext;

  // Decode the incoming request into beat addresses, byte enables and lane data.
  always_comb begin
    w_off   = i_req_addr[OW-1:0];
    w_bytes = 4'd1 << i_req_size;
    w_bmask = '0;
    unique case (i_req_size)
      2'b00: w_bmask = (2*NB)'(1);
      2'b01: w_bmask = (2*NB)'(3);
      2'b10: w_bmask = (2*NB)'(15);
      2'b11: w_bmask = (2*NB)'(8'hFF);
      default: w_bmask = '0;
    endcase
    w_mask   = w_bmask << w_off;
    w_sh0_in = SW'({w_off, 3'b000});
    w_sh1_in = SW'(XLEN) - w_sh0_in;
    w_addr0  = {i_req_addr[XLEN-1:OW], {OW{1'b0}}};
    w_addr1  = w_addr0 + XLEN'(NB);
    w_wdata0 = i_req_wdata << w_sh0_in;
    w_wdata1 = i_req_wdata >> w_sh1_in;
    w_split  = (5'(w_off) + 5'(w_bytes)) > 5'(NB);
`ifdef LSU_MISALIGN_EN
    w_fault  = (i_req_size == 2'b11) && (XLEN == 32);
`else
    w_fault  = ((i_req_size == 2'b11) && (XLEN == 32)) ||
               ((w_off & OW'(w_bytes - 4'd1)) != '0);
`endif
  end

  // Merge the two beats, then truncate to the access size and extend.
  always_comb begin
    w_ld_sh0 = SW'({r_off, 3'b000});
    w_ld_sh1 = SW'(XLEN) - w_ld_sh0;
    if (r_state == StWait1) begin
      w_d0 = r_d0;
      w_d1 = i_mem_rdata;
    end else begin
      w_d0 = i_mem_rdata;
      w_d1 = '0;
    end
    // A shift by XLEN (offset 0) yields zero, so d1 drops out for aligned words.
    w_raw     = (w_d0 >> w_ld_sh0) | (w_d1 << w_ld_sh1);
    w_lowmask = '1;
    w_sign    = w_raw[XLEN-1];
    unique case (r_size)
      2'b00: begin w_lowmask = XLEN'(8'hFF);         w_sign = w_raw[7];      end
      2'b01: begin w_lowmask = XLEN'(16'hFFFF);      w_sign = w_raw[15];     end
      2'b10: begin w_lowmask = XLEN'(32'hFFFF_FFFF); w_sign = w_raw[31];     end
      2'b11: begin w_lowmask = '1;                   w_sign = w_raw[XLEN-1]; end
      default: begin w_lowmask = '1;                 w_sign = w_raw[XLEN-1]; end
    endcase
    w_ext = w_raw & w_lowmask;
    if (!r_unsigned && w_sign) w_ext = w_ext | ~w_lowmask;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= '0;
      r_mem_wdata <= '0;
      r_store     <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_off       <= '0;
      r_split     <= 1'b0;
      r_b1_addr   <= '0;
      r_b1_we     <= '0;
      r_b1_wdata  <= '0;
      r_d0        <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            r_req_ready <= 1'b0;
            r_store     <= i_req_store;
            r_size      <= i_req_size;
            r_unsigned  <= i_req_unsigned;
            r_off       <= w_off;
            r_split     <= w_split;
            r_b1_addr   <= w_addr1;
            r_b1_we     <= i_req_store ? w_mask[2*NB-1:NB] : '0;
            r_b1_wdata  <= i_req_store ? w_wdata1 : '0;
            if (w_fault) begin
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= 1'b1;
              r_state     <= StResp;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_addr  <= w_addr0;
              r_mem_we    <= i_req_store ? w_mask[NB-1:0] : '0;
              r_mem_wdata <= i_req_store ? w_wdata0 : '0;
              r_state     <= StReq0;
            end
          end
        end
        StReq0: begin
          if (i_mem_gnt) begin
            if (r_store && r_split) begin
              // Back-to-back second store beat; mem_req stays high.
              r_mem_addr  <= r_b1_addr;
              r_mem_we    <= r_b1_we;
              r_mem_wdata <= r_b1_wdata;
              r_state     <= StReq1;
            end else begin
              r_mem_req   <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_we    <= '0;
              r_mem_wdata <= '0;
              if (r_store) begin
                r_rsp_valid <= 1'b1;
                r_state     <= StResp;
              end else begin
                r_state     <= StWait0;
              end
            end
          end
        end
        StWait0: begin
          if (i_mem_rvalid) begin
            if (r_split) begin
              r_d0        <= i_mem_rdata;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= r_b1_addr;
              r_mem_we    <= '0;
              r_mem_wdata <= '0;
              r_state     <= StReq1;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_ext;
              r_state     <= StResp;
            end
          end
        end
        StReq1: begin
          if (i_mem_gnt) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= '0;
            r_mem_wdata <= '0;
            if (r_store) begin
              r_rsp_valid <= 1'b1;
              r_state     <= StResp;
            end else begin
              r_state     <= StWait1;
            end
          end
        end
        StWait1: begin
          if (i_mem_rvalid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_ext;
            r_state     <= StResp;
          end
        end
        StResp: begin
          r_rsp_valid <= 1'b0;
          r_rsp_fault <= 1'b0;
          r_rsp_rdata <= '0;
          r_req_ready <= 1'b1;
          r_state     <= StIdle;
        end
        default: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_fault = r_rsp_fault;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wdata = r_mem_wdata;

endmodule
